lsu_rmw: RTL and testbench

Load/store sequencer sitting directly upstream of the data-memory stage. It accepts one load or store request at a time from the execute stage and drives the word-wide, synchronous-read data RAM port. Sub-word stores become read-modify-write sequences because the RAM has only a single whole-word write enable. Loaded bytes and halfwords are extracted by address lane and then sign- or zero-extended.

---
 rtl/lsu_pkg.sv | 34 +++
 rtl/lsu_lane_fmt.sv | 40 ++++
 rtl/lsu_rmw.sv | 162 ++++++++++++++++
 tb/tb_lsu_rmw.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared funct3 encodings, FSM state type and request-classification helpers for lsu_rmw.
package lsu_pkg;

   localparam logic [2:0] L_BYTE  = 3'b000;
   localparam logic [2:0] L_HALF  = 3'b001;
   localparam logic [2:0] L_WORD  = 3'b010;
   localparam logic [2:0] L_BYTEU = 3'b100;
   localparam logic [2:0] L_HALFU = 3'b101;
   localparam logic [2:0] S_BYTE  = 3'b000;
   localparam logic [2:0] S_HALF  = 3'b001;
   localparam logic [2:0] S_WORD  = 3'b010;

   typedef enum logic [2:0] {StIdle, StRd, StWait, StWr, StResp} state_e;

   function automatic logic op_valid(input logic we, input logic [2:0] f3);
      if (we) return (f3 == S_BYTE) || (f3 == S_HALF) || (f3 == S_WORD);
      return (f3 == L_BYTE) || (f3 == L_HALF) || (f3 == L_WORD) ||
             (f3 == L_BYTEU) || (f3 == L_HALFU);
   endfunction

   // funct3[1:0] gives the access size for every legal load and store encoding.
   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
      return ((f3[1:0] == 2'b01) && lo[0]) || ((f3[1:0] == 2'b10) && (lo != 2'b00));
   endfunction

   function automatic logic [1:0] mask_lane(input logic [2:0] f3, input logic [1:0] lo);
      case (f3[1:0])
         2'b01:   return {lo[1], 1'b0};
         2'b10:   return 2'b00;
         default: return lo;
      endcase
   endfunction

endpackage

// File: rtl/lsu_lane_fmt.sv
// Lane extract/extend for loads and lane merge for sub-word stores (purely combinational).
module lsu_lane_fmt
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  lane_i,
   input  logic [31:0] word_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] load_data_o,
   output logic [31:0] merged_o
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v      = word_i[{lane_i, 3'b000} +: 8];
      half_v      = word_i[{lane_i[1], 4'b0000} +: 16];
      load_data_o = '0;
      case (funct3_i)
         L_BYTE:  load_data_o = {{24{byte_v[7]}}, byte_v};
         L_HALF:  load_data_o = {{16{half_v[15]}}, half_v};
         L_WORD:  load_data_o = word_i;
         L_BYTEU: load_data_o = {24'h0, byte_v};
         L_HALFU: load_data_o = {16'h0, half_v};
         default: load_data_o = '0;
      endcase
   end

   always_comb begin
      merged_o = word_i;
      case (funct3_i)
         S_BYTE:  merged_o[{lane_i, 3'b000} +: 8]     = wdata_i[7:0];
         S_HALF:  merged_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
         S_WORD:  merged_o = wdata_i;
         default: merged_o = word_i;
      endcase
   end

endmodule

// File: rtl/lsu_rmw.sv
// Load/store sequencer: one request at a time, sub-word stores as read-modify-write.
// Define LSU_MISALIGN_TRAP_EN to report misaligned accesses instead of masking low address bits.
module lsu_rmw
   import lsu_pkg::*;
#(
   parameter int unsigned ADDR_W = 12
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_misalign,
   output logic              mem_re,
   output logic [ADDR_W-3:0] mem_raddr,
   input  logic [31:0]       mem_rdata,
   output logic              mem_we,
   output logic [ADDR_W-3:0] mem_waddr,
   output logic [31:0]       mem_wdata
);

   state_e            state_q, state_d;
   logic              we_q, we_d;
   logic [2:0]        f3_q, f3_d;
   logic [1:0]        lane_q, lane_d;
   logic [ADDR_W-3:0] word_q, word_d;
   logic [31:0]       wbuf_q, wbuf_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              misalign_q, misalign_d;
   logic              mem_re_q, mem_re_d;
   logic              mem_we_q, mem_we_d;
   logic              rsp_valid_q, rsp_valid_d;

   logic [1:0]        req_lane;
   logic              req_mis;
   logic [31:0]       load_data;
   logic [31:0]       merged;
   logic              unused_addr;

   assign unused_addr = ^req_addr[31:ADDR_W];

`ifdef LSU_MISALIGN_TRAP_EN
   assign req_lane = req_addr[1:0];
   assign req_mis  = misaligned(req_funct3, req_addr[1:0]);
`else
   assign req_lane = mask_lane(req_funct3, req_addr[1:0]);
   assign req_mis  = 1'b0;
`endif

   lsu_lane_fmt u_lane_fmt (
      .funct3_i    (f3_q),
      .lane_i      (lane_q),
      .word_i      (mem_rdata),
      .wdata_i     (wbuf_q),
      .load_data_o (load_data),
      .merged_o    (merged)
   );

   always_comb begin
      state_d     = state_q;
      we_d        = we_q;
      f3_d        = f3_q;
      lane_d      = lane_q;
      word_d      = word_q;
      wbuf_d      = wbuf_q;
      rdata_d     = rdata_q;
      misalign_d  = misalign_q;
      mem_re_d    = 1'b0;
      mem_we_d    = 1'b0;
      rsp_valid_d = 1'b0;
      case (state_q)
         StIdle: begin
            if (req_valid) begin
               we_d       = req_we;
               f3_d       = req_funct3;
               lane_d     = req_lane;
               word_d     = req_addr[ADDR_W-1:2];
               wbuf_d     = req_wdata;
               rdata_d    = '0;
               misalign_d = 1'b0;
               if (!op_valid(req_we, req_funct3)) begin
                  state_d     = StResp;
                  rsp_valid_d = 1'b1;
               end else if (req_mis) begin
                  misalign_d  = 1'b1;
                  state_d     = StResp;
                  rsp_valid_d = 1'b1;
               end else if (req_we && (req_funct3 == S_WORD)) begin
                  state_d  = StWr;
                  mem_we_d = 1'b1;
               end else begin
                  state_d  = StRd;
                  mem_re_d = 1'b1;
               end
            end
         end
         StRd: state_d = StWait;
         StWait: begin
            if (we_q) begin
               wbuf_d   = merged;
               state_d  = StWr;
               mem_we_d = 1'b1;
            end else begin
               rdata_d     = load_data;
               state_d     = StResp;
               rsp_valid_d = 1'b1;
            end
         end
         StWr: begin
            state_d     = StResp;
            rsp_valid_d = 1'b1;
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         we_q        <= 1'b0;
         f3_q        <= '0;
         lane_q      <= '0;
         word_q      <= '0;
         wbuf_q      <= '0;
         rdata_q     <= '0;
         misalign_q  <= 1'b0;
         mem_re_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         we_q        <= we_d;
         f3_q        <= f3_d;
         lane_q      <= lane_d;
         word_q      <= word_d;
         wbuf_q      <= wbuf_d;
         rdata_q     <= rdata_d;
         misalign_q  <= misalign_d;
         mem_re_q    <= mem_re_d;
         mem_we_q    <= mem_we_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

   assign req_ready    = (state_q == StIdle);
   // A reset landing on RD or WR must kill that RAM access in the same cycle.
   assign mem_re       = mem_re_q & ~reset;
   assign mem_we       = mem_we_q & ~reset;
   assign mem_raddr    = word_q;
   assign mem_waddr    = word_q;
   assign mem_wdata    = wbuf_q;
   assign rsp_valid    = rsp_valid_q;
   assign rsp_rdata    = rdata_q;
   assign rsp_misalign = misalign_q;

endmodule

// File: tb/tb_lsu_rmw.sv
// Directed bench for lsu_rmw: word-level reference memory model plus hand-computed literals.
module tb_lsu_rmw;

   localparam int unsigned ADDR_W = 12;

   logic              clk = 1'b0;
   logic              reset;
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [2:0]        req_funct3;
   logic [31:0]       req_addr;
   logic [31:0]       req_wdata;
   logic              rsp_valid;
   logic [31:0]       rsp_rdata;
   logic              rsp_misalign;
   logic              mem_re;
   logic [ADDR_W-3:0] mem_raddr;
   logic [31:0]       mem_rdata;
   logic              mem_we;
   logic [ADDR_W-3:0] mem_waddr;
   logic [31:0]       mem_wdata;

   logic [31:0] ram     [1024];
   logic [31:0] ref_mem [1024];

   int n_cmp = 0;
   int n_bad = 0;

   lsu_rmw #(.ADDR_W(ADDR_W)) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_funct3   (req_funct3),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_rdata    (rsp_rdata),
      .rsp_misalign (rsp_misalign),
      .mem_re       (mem_re),
      .mem_raddr    (mem_raddr),
      .mem_rdata    (mem_rdata),
      .mem_we       (mem_we),
      .mem_waddr    (mem_waddr),
      .mem_wdata    (mem_wdata)
   );

   always #5 clk = ~clk;

   // Synchronous-read RAM seen by the DUT.
   always @(posedge clk) begin
      if (mem_re) mem_rdata <= ram[mem_raddr];
      if (mem_we) ram[mem_waddr] <= mem_wdata;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   task automatic chk1(input string name, input logic got, input logic want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %b want %b", name, got, want);
      end
   endtask

   // Reference: cycle offsets of RAM activity/response and the data they must carry.
   task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output int lat, output int rd_t, output int wr_t,
                        output logic [31:0] e_rd, output logic [31:0] e_wd, output logic e_mis);
      int          sz;
      int          lo;
      logic        ok;
      logic [31:0] w;
      logic [31:0] sh;
      logic [31:0] mask;
      byte         b;
      shortint     h;
      sz    = int'(f3[1:0]);
      lo    = int'(a[1:0]);
      ok    = we ? (f3 <= 3'd2) : ((f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5));
      lat   = 1;
      rd_t  = 0;
      wr_t  = 0;
      e_rd  = 32'h0;
      e_wd  = 32'h0;
      e_mis = 1'b0;
      if (!ok) return;
      if ((sz == 1 && lo % 2 == 1) || (sz == 2 && lo != 0)) begin
`ifdef LSU_MISALIGN_TRAP_EN
         e_mis = 1'b1;
         return;
`else
         lo = (sz == 2) ? 0 : lo - lo % 2;
`endif
      end
      w = ref_mem[a[11:2]];
      if (!we) begin
         rd_t = 1;
         lat  = 3;
         sh   = w >> (8 * lo);
         b    = sh[7:0];
         h    = sh[15:0];
         case (f3)
            3'd0:    e_rd = 32'(int'(b));
            3'd1:    e_rd = 32'(int'(h));
            3'd2:    e_rd = w;
            3'd4:    e_rd = {24'h0, sh[7:0]};
            default: e_rd = {16'h0, sh[15:0]};
         endcase
      end else if (sz == 2) begin
         wr_t = 1;
         lat  = 2;
         e_wd = wd;
         ref_mem[a[11:2]] = wd;
      end else begin
         rd_t = 1;
         wr_t = 3;
         lat  = 4;
         mask = ((sz == 0) ? 32'hff : 32'hffff) << (8 * lo);
         e_wd = (w & ~mask) | ((wd << (8 * lo)) & mask);
         ref_mem[a[11:2]] = e_wd;
      end
   endtask

   // Issue one request at a negedge and check every cycle until req_ready returns.
   // lit_kind: 0 none, 1 pin rsp_rdata, 2 pin mem_wdata. hold keeps req_valid up with junk.
   task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input int lit_kind, input logic [31:0] lit,
                         input bit hold);
      int          lat;
      int          rd_t;
      int          wr_t;
      int          waited;
      logic [31:0] e_rd;
      logic [31:0] e_wd;
      logic        e_mis;
      logic [9:0]  idx;
      model(we, f3, addr, wd, lat, rd_t, wr_t, e_rd, e_wd, e_mis);
      idx        = addr[11:2];
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wd;
      waited     = 0;
      while (!req_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!req_ready) begin
         chk1("accept_timeout", req_ready, 1'b1);
         req_valid = 1'b0;
         return;
      end
      @(negedge clk);
      if (hold) begin
         req_we     = ~we;
         req_funct3 = 3'b010;
         req_addr   = addr ^ 32'h0000_0ffc;
         req_wdata  = ~wd;
      end else begin
         req_valid = 1'b0;
      end
      for (int t = 1; t <= lat + 1; t++) begin
         chk1("req_ready", req_ready, t > lat);
         chk1("mem_re", mem_re, t == rd_t);
         chk1("mem_we", mem_we, t == wr_t);
         chk1("rsp_valid", rsp_valid, t == lat);
         if (t == rd_t) chk("mem_raddr", 32'(mem_raddr), 32'(idx));
         if (t == wr_t) begin
            chk("mem_waddr", 32'(mem_waddr), 32'(idx));
            chk("mem_wdata", mem_wdata, e_wd);
            if (lit_kind == 2) chk("lit_wdata", mem_wdata, lit);
         end
         if (t == lat) begin
            chk("rsp_rdata", rsp_rdata, e_rd);
            chk1("rsp_misalign", rsp_misalign, e_mis);
            if (lit_kind == 1) chk("lit_rdata", rsp_rdata, lit);
         end
         if (t <= lat) @(negedge clk);
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) begin
         ram[i]     = 32'h0;
         ref_mem[i] = 32'h0;
      end
      ram[4]     = 32'h8081_7F22;
      ref_mem[4] = 32'h8081_7F22;
      mem_rdata  = 32'h0;
      reset      = 1'b1;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_funct3 = 3'b000;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      chk1("reset_req_ready", req_ready, 1'b1);
      chk1("reset_rsp_valid", rsp_valid, 1'b0);
      chk1("reset_mem_re", mem_re, 1'b0);
      chk1("reset_mem_we", mem_we, 1'b0);
      chk("reset_rsp_rdata", rsp_rdata, 32'h0);
      chk1("reset_rsp_misalign", rsp_misalign, 1'b0);

      do_req(1'b0, 3'b000, 32'h11, 32'h0, 1, 32'h0000_007F, 1'b0);
      do_req(1'b0, 3'b000, 32'h12, 32'h0, 1, 32'hFFFF_FF81, 1'b0);
      do_req(1'b0, 3'b100, 32'h13, 32'h0, 1, 32'h0000_0080, 1'b0);
      do_req(1'b0, 3'b001, 32'h12, 32'h0, 1, 32'hFFFF_8081, 1'b0);
      do_req(1'b0, 3'b101, 32'h10, 32'h0, 1, 32'h0000_7F22, 1'b0);
      do_req(1'b1, 3'b000, 32'h12, 32'h0000_00AB, 2, 32'h80AB_7F22, 1'b0);
      do_req(1'b0, 3'b010, 32'h10, 32'h0, 1, 32'h80AB_7F22, 1'b0);
      do_req(1'b1, 3'b001, 32'h12, 32'h0000_1234, 2, 32'h1234_7F22, 1'b0);
      do_req(1'b0, 3'b010, 32'h10, 32'h0, 1, 32'h1234_7F22, 1'b0);
      do_req(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 2, 32'hDEAD_BEEF, 1'b0);
      do_req(1'b0, 3'b010, 32'h10, 32'h0, 1, 32'hDEAD_BEEF, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
      do_req(1'b0, 3'b010, 32'h11, 32'h0, 1, 32'h0, 1'b0);
      do_req(1'b1, 3'b001, 32'h13, 32'h0000_CAFE, 0, 32'h0, 1'b0);
      do_req(1'b0, 3'b010, 32'h10, 32'h0, 1, 32'hDEAD_BEEF, 1'b0);
`else
      do_req(1'b0, 3'b010, 32'h11, 32'h0, 1, 32'hDEAD_BEEF, 1'b0);
      do_req(1'b1, 3'b001, 32'h13, 32'h0000_CAFE, 2, 32'hCAFE_BEEF, 1'b0);
      do_req(1'b0, 3'b010, 32'h10, 32'h0, 1, 32'hCAFE_BEEF, 1'b0);
`endif
      do_req(1'b0, 3'b011, 32'h10, 32'h0, 1, 32'h0, 1'b0);
      do_req(1'b1, 3'b011, 32'h10, 32'h1111_1111, 1, 32'h0, 1'b0);
      do_req(1'b0, 3'b110, 32'h10, 32'h0, 1, 32'h0, 1'b0);

      // Back-to-back with req_valid held high throughout.
      do_req(1'b0, 3'b000, 32'h13, 32'h0, 0, 32'h0, 1'b1);
      do_req(1'b1, 3'b000, 32'h11, 32'h0000_0055, 0, 32'h0, 1'b1);
      do_req(1'b0, 3'b010, 32'h10, 32'h0, 0, 32'h0, 1'b1);
      do_req(1'b1, 3'b010, 32'h24, 32'h0000_F00F, 0, 32'h0, 1'b1);
      do_req(1'b0, 3'b101, 32'h26, 32'h0, 1, 32'h0, 1'b1);
      do_req(1'b0, 3'b001, 32'h24, 32'h0, 1, 32'hFFFF_F00F, 1'b0);

      // SB interrupted by a one-cycle reset in its WR cycle.
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_funct3 = 3'b000;
      req_addr   = 32'h12;
      req_wdata  = 32'h0000_005A;
      chk1("rst_sb_ready", req_ready, 1'b1);
      @(negedge clk);
      req_valid = 1'b0;
      chk1("rst_sb_rd", mem_re, 1'b1);
      @(negedge clk);
      @(negedge clk);
      chk1("rst_sb_wr_before", mem_we, 1'b1);
      reset = 1'b1;
      #1;
      chk1("rst_sb_we_gated", mem_we, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk1("rst_sb_ready_after", req_ready, 1'b1);
      chk1("rst_sb_no_rsp", rsp_valid, 1'b0);
      chk("rst_sb_ram", ram[4], ref_mem[4]);
      do_req(1'b0, 3'b010, 32'h10, 32'h0, 0, 32'h0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
